stage_fifo: RTL and testbench

Parametrised valid/ready pipeline stage buffer for the multi-cycle core. It replaces the fixed single-register stage buses between IF, ID, EX, MEM and WB with a DEPTH-entry circular buffer of DATA_W-bit payload words. It adds a synchronous flush for redirect and trap, an occupancy output, and optional zero-latency bypass. Upstream `ready` is registered-only, which breaks the combinational ready chain from WB back to IF.

---
 rtl/stage_fifo.sv | 99 +++++++++
 tb/tb_stage_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage_fifo.sv
// Valid/ready pipeline stage buffer: DEPTH-entry circular buffer with flush and occupancy output.
// Optional zero-latency bypass when empty is enabled by defining STAGE_FIFO_BYPASS_EN.
module stage_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic [DATA_W-1:0]          s_data_i,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [DATA_W-1:0]          m_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    logic empty, full, byp_valid, byp_take, push, pop;

    // DEPTH is a power of two, so natural wrap works except for the single-entry case.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (DEPTH == 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FullCnt);
        s_ready_o = ~full;
`ifdef STAGE_FIFO_BYPASS_EN
        byp_valid = empty & ~flush_i & s_valid_i;
`else
        byp_valid = 1'b0;
`endif
        m_valid_o = ~empty | byp_valid;
        m_data_o  = byp_valid ? s_data_i : mem_q[rd_ptr_q];
        // A beat consumed straight through the bypass never touches storage.
        byp_take  = byp_valid & m_ready_i;
        push      = s_valid_i & ~full & ~flush_i & ~byp_take;
        pop       = ~empty & m_ready_i;
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= s_data_i;
        end
    end

    assign count_o = count_q;

`ifndef SYNTHESIS
    count_le_depth: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= FullCnt);
`endif

endmodule

// File: tb/tb_stage_fifo.sv
// Self-checking bench for stage_fifo (DEPTH=2): scoreboard of expected beats plus per-scenario
// checks of occupancy, handshake and flush/reset behaviour.
module tb_stage_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [1:0]  count;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    bit          done = 1'b0;

    stage_fifo #(.DATA_W(32), .DEPTH(2)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .flush_i  (flush),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .s_data_i (s_data),
        .m_valid_o(m_valid),
        .m_ready_i(m_ready),
        .m_data_o (m_data),
        .count_o  (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        #2;
        tests_run++; if (count !== 2'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count); end
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        tests_run++; if (m_data !== 32'h0) begin tests_failed++; $display("FAIL reset_m_data: got %0h want 0", m_data); end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        tests_run++; if (count !== 2'd0) begin tests_failed++; $display("FAIL post_reset_count: got %0d want 0", count); end
    endtask

    task automatic test_fill();
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 32'h11; exp_q.push_back(32'h11);
        tick();
        tests_run++; if (count !== 2'd1) begin tests_failed++; $display("FAIL fill_count1: got %0d want 1", count); end
        tests_run++; if (m_data !== 32'h11) begin tests_failed++; $display("FAIL fill_head1: got %0h want 11", m_data); end
        s_data = 32'h22; exp_q.push_back(32'h22);
        tick();
        tests_run++; if (count !== 2'd2) begin tests_failed++; $display("FAIL fill_count2: got %0d want 2", count); end
        tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_s_ready: got %b want 0", s_ready); end
        tests_run++; if (m_data !== 32'h11) begin tests_failed++; $display("FAIL fill_head2: got %0h want 11", m_data); end
    endtask

    task automatic test_backpressure();
        // Buffer is full: 0x33 must be refused even though this cycle pops.
        s_valid = 1'b1; s_data = 32'h33; m_ready = 1'b1;
        tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_s_ready_full: got %b want 0", s_ready); end
        tick();
        tests_run++; if (count !== 2'd1) begin tests_failed++; $display("FAIL bp_count: got %0d want 1", count); end
        tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_s_ready: got %b want 1", s_ready); end
        tests_run++; if (m_data !== 32'h22) begin tests_failed++; $display("FAIL bp_head: got %0h want 22", m_data); end
        s_valid = 1'b0;
        tick();
        tests_run++; if (count !== 2'd0) begin tests_failed++; $display("FAIL bp_drain_count: got %0d want 0", count); end
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain_m_valid: got %b want 0", m_valid); end
        m_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [1:0] want_cnt;
`ifdef STAGE_FIFO_BYPASS_EN
        want_cnt = 2'd0;
`else
        want_cnt = 2'd1;
`endif
        s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data = 32'(i);
            exp_q.push_back(32'(i));
            tick();
            tests_run++;
            if (count !== want_cnt) begin
                tests_failed++; $display("FAIL stream_count[%0d]: got %0d want %0d", i, count, want_cnt);
            end
        end
        s_valid = 1'b0;
        tick();
        tests_run++; if (count !== 2'd0) begin tests_failed++; $display("FAIL stream_drain: got %0d want 0", count); end
        m_ready = 1'b0;
    endtask

    task automatic test_flush();
        m_ready = 1'b0; s_valid = 1'b1;
        s_data = 32'hA1; exp_q.push_back(32'hA1); tick();
        s_data = 32'hA2; exp_q.push_back(32'hA2); tick();
        tests_run++; if (count !== 2'd2) begin tests_failed++; $display("FAIL flush_pre_count: got %0d want 2", count); end
        // Head 0xA1 is delivered this cycle; 0xA2 and 0x44 are dropped.
        flush = 1'b1; s_data = 32'h44; m_ready = 1'b1;
        tick();
        exp_q.delete();
        flush = 1'b0; s_valid = 1'b0;
        tests_run++; if (count !== 2'd0) begin tests_failed++; $display("FAIL flush_count: got %0d want 0", count); end
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_m_valid: got %b want 0", m_valid); end
        repeat (2) tick();
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_no_44: got %b want 0", m_valid); end
        m_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        m_ready = 1'b0; s_valid = 1'b1;
        s_data = 32'hB1; exp_q.push_back(32'hB1); tick();
        s_data = 32'hB2; exp_q.push_back(32'hB2); tick();
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL arst_m_valid: got %b want 0", m_valid); end
        tests_run++; if (count !== 2'd0) begin tests_failed++; $display("FAIL arst_count: got %0d want 0", count); end
        tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL arst_s_ready: got %b want 1", s_ready); end
        tick();
        rst = 1'b0;
        #1;
        tests_run++; if (m_data !== 32'h0) begin tests_failed++; $display("FAIL arst_m_data: got %0h want 0", m_data); end
        s_valid = 1'b1; s_data = 32'hC3; m_ready = 1'b1; exp_q.push_back(32'hC3);
        tick();
        s_valid = 1'b0;
        tick();
        tests_run++; if (count !== 2'd0) begin tests_failed++; $display("FAIL arst_resume_count: got %0d want 0", count); end
        m_ready = 1'b0;
    endtask

`ifdef STAGE_FIFO_BYPASS_EN
    task automatic test_bypass();
        s_valid = 1'b1; s_data = 32'h55; m_ready = 1'b1; exp_q.push_back(32'h55);
        #1;
        tests_run++; if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL byp_m_valid: got %b want 1", m_valid); end
        tests_run++; if (m_data !== 32'h55) begin tests_failed++; $display("FAIL byp_m_data: got %0h want 55", m_data); end
        tick();
        tests_run++; if (count !== 2'd0) begin tests_failed++; $display("FAIL byp_count: got %0d want 0", count); end
        s_data = 32'h66; m_ready = 1'b0; exp_q.push_back(32'h66);
        tick();
        tests_run++; if (count !== 2'd1) begin tests_failed++; $display("FAIL byp_store_count: got %0d want 1", count); end
        s_valid = 1'b0; m_ready = 1'b1;
        tick();
        m_ready = 1'b0; flush = 1'b1; s_valid = 1'b1; s_data = 32'h77;
        #1;
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL byp_flush_m_valid: got %b want 0", m_valid); end
        tick();
        flush = 1'b0; s_valid = 1'b0;
        tests_run++; if (count !== 2'd0) begin tests_failed++; $display("FAIL byp_flush_count: got %0d want 0", count); end
    endtask
`else
    task automatic test_no_bypass();
        s_valid = 1'b1; s_data = 32'h55; m_ready = 1'b1;
        #1;
        tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL nobyp_m_valid: got %b want 0", m_valid); end
        exp_q.push_back(32'h55);
        tick();
        tests_run++; if (count !== 2'd1) begin tests_failed++; $display("FAIL nobyp_count: got %0d want 1", count); end
        tests_run++; if (m_data !== 32'h55) begin tests_failed++; $display("FAIL nobyp_m_data: got %0h want 55", m_data); end
        s_valid = 1'b0;
        tick();
        tests_run++; if (count !== 2'd0) begin tests_failed++; $display("FAIL nobyp_drain: got %0d want 0", count); end
        m_ready = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        fork
            begin
                test_reset();
                test_fill();
                test_backpressure();
                test_stream();
                test_flush();
                test_async_reset();
`ifdef STAGE_FIFO_BYPASS_EN
                test_bypass();
`else
                test_no_bypass();
`endif
                tick();
                done = 1'b1;
            end
            begin
                // Scoreboard consumer: every downstream handshake must match the oldest expected beat.
                while (!done) begin
                    @(negedge clk);
                    if (m_valid === 1'b1 && m_ready === 1'b1) begin
                        tests_run++;
                        if (exp_q.size() == 0) begin
                            tests_failed++;
                            $display("FAIL sb_unexpected: got %0h want no beat", m_data);
                        end else begin
                            logic [31:0] want;
                            want = exp_q.pop_front();
                            if (m_data !== want) begin
                                tests_failed++;
                                $display("FAIL sb_data: got %0h want %0h", m_data, want);
                            end
                        end
                    end
                end
            end
        join
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: got %0d beats outstanding want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
